parallel_pe: RTL
================

# parallel_pe

Parametrised multi-lane multiply-accumulate processing element, the successor to the single-lane serial PE. Each valid beat multiplies LANES signed neuron/weight pairs, reduces the products through a registered adder tree, and accumulates into a window accumulator. Accumulation windows are delimited by `ctl`. Each window produces a full-precision result, a rounded/saturated DW-bit quantised result and an overflow flag. The block is the compute element instantiated by the PE-array controller.

## Interface
- `DW`, 16, signed element width of neuron and weight
- `LANES`, 4, parallel multiply lanes (≥1; power of two not required)
- `ACC_W`, 32, accumulator and `result` width
- `SAT`, 1, 1 = saturating accumulation, 0 = two's-complement wrap
- `SHIFT`, 8, right shift applied to produce `result_q` (0 ≤ SHIFT < ACC_W)
- `clk` input 1: clock, rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `neuron` input LANES*DW: packed signed elements, lane i at bits [i*DW +: DW]
- `weight` input LANES*DW: packed signed elements, same packing
- `ctl` input 2: bit0 = FIRST (load, do not add), bit1 = LAST (emit result)
- `vld_i` input 1: beat valid; `neuron`, `weight` and `ctl` are sampled only when high
- `result` output ACC_W: accumulator contents, signed
- `result_q` output DW: quantised accumulator, signed
- `ovf_o` output 1: overflow occurred in the emitted window
- `vld_o` output 1: one-cycle pulse marking an emitted window

## Operation
- **Stage 1 (MUL):**
  - LANES products of width 2*DW (signed × signed) are registered.
  - `ctl` and `vld_i` are registered alongside the products.
- **Stage 2 (TREE):**
  - Products are summed at full precision TW = 2*DW + ceil(log2(LANES)).
  - The sum is registered with its ctl/valid.
- **Stage 3 (ACC), performed only when the stage-2 valid bit is set:**
  - Candidate value:
    - FIRST = 1: candidate = tree sum.
    - FIRST = 0: candidate = acc + tree sum.
  - The candidate is computed at max(TW, ACC_W)+1 bits, with no intermediate loss.
  - Candidate outside the signed ACC_W range:
    - SAT = 1: clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
    - SAT = 0: keep the low ACC_W bits.
    - In both modes, set the sticky overflow flag.
  - Sticky overflow flag:
    - FIRST = 1: flag = this beat's overflow.
    - FIRST = 0: flag |= this beat's overflow.
  - LAST = 1: `vld_o` is asserted on the next cycle; `ovf_o` = sticky flag including this beat.
- **Bubbles:** with stage-2 valid = 0, acc, flag and `result` hold, and `vld_o` = 0.
- **No FIRST after reset:** beats accumulate onto 0.
- **ctl = 2'b11:** single-beat window.
- **`result_q` (combinational from acc):**
  - SHIFT > 0: (acc + 2^(SHIFT-1)) >>> SHIFT, computed at ACC_W+1 bits (round half up).
  - SHIFT = 0: acc.
  - The value is then saturated to the signed DW range.
- **Persistence:** `result`, `result_q` and `ovf_o` hold after `vld_o` drops, until the next stage-3 update.
- **Flow control:** none. There is no backpressure; a beat is accepted every cycle `vld_i` = 1.

## Timing
- **Reset values:** all pipeline valid bits 0, acc 0, flag 0. Hence `result` = 0, `result_q` = 0, `ovf_o` = 0, `vld_o` = 0.
- **Latency:** a beat sampled at rising edge E updates acc at edge E+2. When that beat has LAST, `vld_o` is high during exactly the cycle between edges E+2 and E+3.
- **Throughput:** one beat per cycle.
  - Back-to-back windows are allowed: a FIRST beat may immediately follow a LAST beat.
  - A continuous `ctl` = 11 stream produces `vld_o` every cycle.
- **Mid-operation reset:** asserting `rst_n` low discards all in-flight beats and the partial window immediately (asynchronous). The first beat after release is treated per its own `ctl`.
- **Ignored inputs:** `ctl` with `vld_i` = 0 has no effect.

## Test plan
1. **Single-beat window.** Defaults; `neuron` = {4,3,2,1}, `weight` = {8,7,6,5} (lane3..lane0), `ctl` = 11, one beat → 2 edges later: `result` = 70, `result_q` = 0, `ovf_o` = 0, `vld_o` = 1 for exactly one cycle.
2. **Three-beat window with bubbles.** Beats FIRST, mid, LAST with `vld_i` gaps of 0, 2 and 1 cycles. Lane values give tree sums 10, -3 and 100 → one `vld_o` pulse; `result` = 107; no pulse on the non-LAST beats.
3. **Overflow.** All lanes -32768 × -32768, `ctl` = 11:
   - SAT = 1 → `result` = 0x7FFFFFFF, `result_q` = 0x7FFF, `ovf_o` = 1.
   - SAT = 0 → `result` = 0x00000000, `ovf_o` = 1.
   - A following clean window → `ovf_o` = 0.
4. **Rounding, SHIFT = 8.** acc = 384 → `result_q` = 2; acc = 383 → 1; acc = -384 → -1; acc = -385 → -2.
5. **Back-to-back windows.** Four consecutive `ctl` = 11 beats with tree sums 1, 2, 3, 4 → `vld_o` high for 4 consecutive cycles with `result` = 1, 2, 3, 4.
6. **Reset mid-window.** FIRST beat (sum 50), then `rst_n` pulsed low while a LAST beat is in stage 2 → no `vld_o`, `result` = 0. A subsequent LAST-only beat (sum 5) gives `result` = 5.

Source files
------------

// File: rtl/parallel_pe.sv
// Multi-lane signed multiply-accumulate processing element.
// Three-stage pipeline: lane products, reduction sum, then window accumulation with a quantised output.
module parallel_pe #(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int ACC_W = 32,
  parameter int SAT   = 1,
  parameter int SHIFT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LANES*DW-1:0]      neuron,
  input  logic [LANES*DW-1:0]      weight,
  input  logic [1:0]               ctl,
  input  logic                     vld_i,
  output logic signed [ACC_W-1:0]  result,
  output logic signed [DW-1:0]     result_q,
  output logic                     ovf_o,
  output logic                     vld_o
);

  localparam int PW = 2 * DW;
  localparam int TW = PW + $clog2(LANES);
  localparam int CW = ((TW > ACC_W) ? TW : ACC_W) + 1;
  localparam int QW = ACC_W + 1;

  typedef struct packed {
    logic last;
    logic first;
  } ctl_t;

  logic signed [DW-1:0] n_lane [LANES];
  logic signed [DW-1:0] w_lane [LANES];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      n_lane[i] = neuron[i*DW +: DW];
      w_lane[i] = weight[i*DW +: DW];
    end
  end

  // Stage 1: lane products
  logic signed [PW-1:0] prod_q [LANES];
  ctl_t                 ctl1_q;
  logic                 vld1_q;

  // NOTE: only valid bits, the accumulator and the flag need reset; data registers
  // are qualified by their valid bit, so they load freely without a reset term.
  always_ff @(posedge clk) begin
    if (vld_i) begin
      for (int i = 0; i < LANES; i++) begin
        prod_q[i] <= PW'(n_lane[i]) * PW'(w_lane[i]);
      end
      ctl1_q <= ctl;
    end
  end

  // NOTE: sequential state always uses non-blocking assignment so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld1_q <= 1'b0;
    else        vld1_q <= vld_i;
  end

  // Stage 2: full-precision reduction
  logic signed [TW-1:0] tree_sum;
  logic signed [TW-1:0] sum2_q;
  ctl_t                 ctl2_q;
  logic                 vld2_q;

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      tree_sum = tree_sum + TW'(prod_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (vld1_q) begin
      sum2_q <= tree_sum;
      ctl2_q <= ctl1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld2_q <= 1'b0;
    else        vld2_q <= vld1_q;
  end

  // Stage 3: window accumulation with overflow detection at widened precision
  logic signed [ACC_W-1:0] acc_q;
  logic                    flag_q;
  logic signed [CW-1:0]    base;
  logic signed [CW-1:0]    cand;
  logic                    ovf_beat;
  logic [ACC_W-1:0]        acc_next;

  always_comb begin
    base     = ctl2_q.first ? '0 : CW'(acc_q);
    cand     = base + CW'(sum2_q);
    // In range exactly when every bit from the ACC_W sign position upward agrees.
    ovf_beat = ~(&cand[CW-1:ACC_W-1] | ~|cand[CW-1:ACC_W-1]);
    acc_next = cand[ACC_W-1:0];
    if (ovf_beat && SAT != 0) begin
      acc_next = cand[CW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      flag_q <= 1'b0;
      vld_o  <= 1'b0;
    end else begin
      vld_o <= vld2_q & ctl2_q.last;
      if (vld2_q) begin
        acc_q  <= acc_next;
        flag_q <= ovf_beat | (~ctl2_q.first & flag_q);
      end
    end
  end

  assign result = acc_q;
  assign ovf_o  = flag_q;

  // Quantisation: round half up, arithmetic shift, then clamp to DW bits
  logic signed [QW-1:0] shf;

  if (SHIFT > 0) begin : g_round
    localparam logic signed [QW-1:0] HALF = QW'(1) <<< (SHIFT - 1);
    logic signed [QW-1:0] rnd;
    always_comb begin
      rnd = QW'(acc_q) + HALF;
      shf = rnd >>> SHIFT;
    end
  end else begin : g_noround
    assign shf = QW'(acc_q);
  end

  if (DW >= QW) begin : g_wide_q
    assign result_q = DW'(shf);
  end else begin : g_sat_q
    localparam logic signed [QW-1:0] Q_MAX = (QW'(1) <<< (DW - 1)) - QW'(1);
    localparam logic signed [QW-1:0] Q_MIN = -Q_MAX - QW'(1);
    always_comb begin
      result_q = shf[DW-1:0];
      if (shf > Q_MAX)      result_q = {1'b0, {(DW-1){1'b1}}};
      else if (shf < Q_MIN) result_q = {1'b1, {(DW-1){1'b0}}};
    end
  end

endmodule
